// File: rtl/subbytes_seq.sv
// AES SubBytes sequencer: streams a 128-bit state through a shared bank of
// NUM_SBOX registered sbox lanes, GROUPS bytes-groups per state, and reassembles the result.
module subbytes_seq #(
  parameter int unsigned NUM_SBOX = 4,
  parameter int unsigned SBOX_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          state_in,
  output logic [8*NUM_SBOX-1:0] sb_in,
  input  logic [8*NUM_SBOX-1:0] sb_out,
  output logic                  sb_active,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          state_out,
  output logic                  busy
);

  localparam int unsigned GROUPS = 16 / NUM_SBOX;
  localparam int unsigned CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int unsigned W      = 8 * NUM_SBOX;
  localparam logic [CW-1:0] LAST = CW'(GROUPS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          issue_nx;
  logic          accept;
  logic [127:0]  data_q;
  logic [127:0]  src;
  logic [W-1:0]  sb_nx;

  // Tracks which group is due back from the bank, independent of the FSM counter
  logic [SBOX_LAT-1:0] pv;
  logic [CW-1:0]       pidx [SBOX_LAT];
  logic                cap;
  logic [CW-1:0]       cap_idx;
  logic                cap_last;

  function automatic logic [7:0] get_byte(input logic [127:0] v, input int unsigned i);
    return v[127 - 8*i -: 8];
  endfunction

  assign cap      = pv[SBOX_LAT-1];
  assign cap_idx  = pidx[SBOX_LAT-1];
  assign cap_last = cap && (cap_idx == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state and the group to present on the bank next cycle
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    issue_nx = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nx = ISSUE;
          cnt_nx   = '0;
          issue_nx = 1'b1;
          accept   = 1'b1;
        end
      end
      ISSUE: begin
        if (cnt == LAST) begin
          state_nx = WAIT;
        end else begin
          cnt_nx   = cnt + CW'(1);
          issue_nx = 1'b1;
        end
      end
      WAIT: begin
        if (cap_last) state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    src   = accept ? state_in : data_q;
    sb_nx = '0;
    if (issue_nx) begin
      for (int k = 0; k < NUM_SBOX; k++) begin
        sb_nx[8*k +: 8] = get_byte(src, 32'(cnt_nx) * NUM_SBOX + 32'(k));
      end
    end
  end

  // Capture tracking pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      for (int j = 0; j < SBOX_LAT; j++) pidx[j] <= '0;
    end else begin
      pv[0]   <= (state == ISSUE);
      pidx[0] <= cnt;
      for (int j = 1; j < SBOX_LAT; j++) begin
        pv[j]   <= pv[j-1];
        pidx[j] <= pidx[j-1];
      end
    end
  end

  // Registered outputs and result assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      sb_active <= 1'b0;
      sb_in     <= '0;
      data_q    <= '0;
      state_out <= '0;
    end else begin
      in_ready  <= (state_nx == IDLE);
      busy      <= (state_nx != IDLE);
      out_valid <= (state_nx == DONE);
      sb_active <= issue_nx;
      sb_in     <= sb_nx;
      if (accept) data_q <= state_in;
      if (cap) begin
        for (int k = 0; k < NUM_SBOX; k++) begin
          state_out[127 - 8*(32'(cap_idx) * NUM_SBOX + 32'(k)) -: 8] <= sb_out[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_subbytes_seq.sv
// Bench for subbytes_seq: several lane/latency configurations, each fed by a modelled
// sbox bank; results checked against an sbox table derived from GF(2^8) arithmetic.
module tb_subbytes_seq;

  localparam int NCFG = 5;
  localparam int NS_TAB [NCFG] = '{4, 1, 16, 1, 16};
  localparam int LT_TAB [NCFG] = '{1, 1, 1, 3, 3};

  logic         clk;
  logic         rst;
  logic         in_valid  [NCFG];
  logic         in_ready  [NCFG];
  logic [127:0] state_in  [NCFG];
  logic         out_valid [NCFG];
  logic         out_ready [NCFG];
  logic [127:0] state_out [NCFG];
  logic         busy      [NCFG];
  logic         sb_active [NCFG];
  logic [127:0] sb_in_w   [NCFG];

  logic [7:0] sbox_tab [256];
  int cycnt = 0;
  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycnt <= cycnt + 1;

  for (genvar i = 0; i < NCFG; i++) begin : g_dut
    localparam int NSB = NS_TAB[i];
    localparam int LAT = LT_TAB[i];
    logic [8*NSB-1:0] sbi, sbo;
    logic [8*NSB-1:0] bp [LAT];

    subbytes_seq #(.NUM_SBOX(NSB), .SBOX_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[i]), .in_ready(in_ready[i]), .state_in(state_in[i]),
      .sb_in(sbi), .sb_out(sbo), .sb_active(sb_active[i]),
      .out_valid(out_valid[i]), .out_ready(out_ready[i]), .state_out(state_out[i]),
      .busy(busy[i])
    );

    // Sbox bank model with LAT register stages
    always @(posedge clk) begin
      for (int k = 0; k < NSB; k++) bp[0][8*k +: 8] <= sbox_tab[sbi[8*k +: 8]];
      for (int j = 1; j < LAT; j++) bp[j] <= bp[j-1];
    end
    assign sbo = bp[LAT-1];
    assign sb_in_w[i] = 128'(sbi);
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_table();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_tab[s[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Sends one state on config c and returns when out_valid is first seen (out_ready held high)
  task automatic run_one(input int c, input logic [127:0] s, output logic [127:0] res,
                         output int lat, output bit ok, output int acc);
    int n;
    @(negedge clk);
    out_ready[c] = 1'b1;
    in_valid[c]  = 1'b1;
    state_in[c]  = s;
    n = 0;
    while (!in_ready[c] && n < 100) begin @(negedge clk); n++; end
    acc = cycnt;
    @(negedge clk);
    in_valid[c] = 1'b0;
    lat = 1;
    while (!out_valid[c] && lat < 200) begin @(negedge clk); lat++; end
    ok  = out_valid[c];
    res = state_out[c];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int c = 0; c < NCFG; c++) begin
      n_cmp += 5;
      if (in_ready[c] !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready cfg%0d got %b want 1", c, in_ready[c]); end
      if (out_valid[c] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid cfg%0d got %b want 0", c, out_valid[c]); end
      if (busy[c] !== 1'b0 || sb_active[c] !== 1'b0) begin
        n_bad++; $display("FAIL reset_busy_active cfg%0d got %b%b want 00", c, busy[c], sb_active[c]);
      end
      if (sb_in_w[c] !== 128'h0) begin n_bad++; $display("FAIL reset_sb_in cfg%0d got %h want 0", c, sb_in_w[c]); end
      if (state_out[c] !== 128'h0) begin n_bad++; $display("FAIL reset_state_out cfg%0d got %h want 0", c, state_out[c]); end
    end
    rst = 1'b0;
  endtask

  task automatic test_known_vectors();
    logic [127:0] vin [3];
    logic [127:0] vexp [3];
    logic [127:0] res;
    int lat, acc;
    bit ok;
    vin[0] = 128'h193de3bea0f4e22b9ac68d2ae9f84808; vexp[0] = 128'hd42711aee0bf98f1b8b45de51e415230;
    vin[1] = 128'h0;                               vexp[1] = {16{8'h63}};
    vin[2] = {16{8'hff}};                          vexp[2] = {16{8'h16}};
    for (int t = 0; t < 3; t++) begin
      run_one(0, vin[t], res, lat, ok, acc);
      n_cmp += 3;
      if (!ok) begin n_bad++; $display("FAIL vec%0d_timeout out_valid never rose", t); end
      if (res !== vexp[t]) begin n_bad++; $display("FAIL vec%0d_data got %h want %h", t, res, vexp[t]); end
      if (res !== ref_sub(vin[t])) begin n_bad++; $display("FAIL vec%0d_model got %h want %h", t, res, ref_sub(vin[t])); end
    end
  endtask

  task automatic test_latency();
    logic [127:0] s, exp_lanes;
    int n;
    bit e_act, e_rdy, e_ov;
    s = rand128();
    n = 0;
    @(negedge clk);
    while (!in_ready[0] && n < 100) begin @(negedge clk); n++; end
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    state_in[0]  = s;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      if (cyc == 1) in_valid[0] = 1'b0;
      e_act = (cyc >= 1 && cyc <= 4);
      e_rdy = !(cyc >= 1 && cyc <= 6);
      e_ov  = (cyc == 6);
      exp_lanes = '0;
      if (e_act)
        for (int k = 0; k < 4; k++) exp_lanes[8*k +: 8] = s[127 - 8*((cyc-1)*4 + k) -: 8];
      n_cmp += 5;
      if (sb_active[0] !== e_act) begin n_bad++; $display("FAIL lat_sb_active c%0d got %b want %b", cyc, sb_active[0], e_act); end
      if (in_ready[0] !== e_rdy) begin n_bad++; $display("FAIL lat_in_ready c%0d got %b want %b", cyc, in_ready[0], e_rdy); end
      if (out_valid[0] !== e_ov) begin n_bad++; $display("FAIL lat_out_valid c%0d got %b want %b", cyc, out_valid[0], e_ov); end
      if (busy[0] !== !e_rdy) begin n_bad++; $display("FAIL lat_busy c%0d got %b want %b", cyc, busy[0], !e_rdy); end
      if (sb_in_w[0] !== exp_lanes) begin n_bad++; $display("FAIL lat_sb_in c%0d got %h want %h", cyc, sb_in_w[0], exp_lanes); end
      if (cyc == 6) begin
        n_cmp++;
        if (state_out[0] !== ref_sub(s)) begin n_bad++; $display("FAIL lat_data got %h want %h", state_out[0], ref_sub(s)); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] s1, s2;
    int n, lat;
    s1 = rand128();
    s2 = rand128();
    n = 0;
    @(negedge clk);
    while (!in_ready[0] && n < 100) begin @(negedge clk); n++; end
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    state_in[0]  = s1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 100) begin @(negedge clk); n++; end
    in_valid[0] = 1'b1;
    state_in[0] = s2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp += 3;
      if (out_valid[0] !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid i%0d got %b want 1", i, out_valid[0]); end
      if (state_out[0] !== ref_sub(s1)) begin n_bad++; $display("FAIL bp_hold i%0d got %h want %h", i, state_out[0], ref_sub(s1)); end
      if (in_ready[0] !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready i%0d got %b want 0", i, in_ready[0]); end
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    n_cmp += 3;
    if (out_valid[0] !== 1'b0) begin n_bad++; $display("FAIL bp_consume_ov got %b want 0", out_valid[0]); end
    if (in_ready[0] !== 1'b1) begin n_bad++; $display("FAIL bp_consume_rdy got %b want 1", in_ready[0]); end
    if (state_out[0] !== ref_sub(s1)) begin n_bad++; $display("FAIL bp_after_hold got %h want %h", state_out[0], ref_sub(s1)); end
    @(negedge clk);
    in_valid[0] = 1'b0;
    lat = 1;
    while (!out_valid[0] && lat < 200) begin @(negedge clk); lat++; end
    n_cmp += 2;
    if (lat !== 6) begin n_bad++; $display("FAIL bp_next_latency got %0d want 6", lat); end
    if (state_out[0] !== ref_sub(s2)) begin n_bad++; $display("FAIL bp_next_data got %h want %h", state_out[0], ref_sub(s2)); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] s, res, g2;
    int n, lat, acc;
    bit ok;
    s = rand128();
    n = 0;
    @(negedge clk);
    while (!in_ready[0] && n < 100) begin @(negedge clk); n++; end
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    state_in[0]  = s;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    g2 = '0;
    for (int k = 0; k < 4; k++) g2[8*k +: 8] = s[127 - 8*(8 + k) -: 8];
    n_cmp += 2;
    if (sb_active[0] !== 1'b1) begin n_bad++; $display("FAIL rm_group2_active got %b want 1", sb_active[0]); end
    if (sb_in_w[0] !== g2) begin n_bad++; $display("FAIL rm_group2_lanes got %h want %h", sb_in_w[0], g2); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp += 5;
    if (out_valid[0] !== 1'b0) begin n_bad++; $display("FAIL rm_out_valid got %b want 0", out_valid[0]); end
    if (sb_active[0] !== 1'b0) begin n_bad++; $display("FAIL rm_sb_active got %b want 0", sb_active[0]); end
    if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_bad++; $display("FAIL rm_idle got rdy=%b busy=%b want 1 0", in_ready[0], busy[0]);
    end
    if (sb_in_w[0] !== 128'h0) begin n_bad++; $display("FAIL rm_sb_in got %h want 0", sb_in_w[0]); end
    if (state_out[0] !== 128'h0) begin n_bad++; $display("FAIL rm_state_out got %h want 0", state_out[0]); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (state_out[0] !== 128'h0) begin n_bad++; $display("FAIL rm_dropped got %h want 0", state_out[0]); end
    s = rand128();
    run_one(0, s, res, lat, ok, acc);
    n_cmp += 2;
    if (!ok || lat !== 6) begin n_bad++; $display("FAIL rm_recover_latency got %0d want 6", lat); end
    if (res !== ref_sub(s)) begin n_bad++; $display("FAIL rm_recover_data got %h want %h", res, ref_sub(s)); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] s, res;
    int lat, acc, prev_acc, g, l;
    bit ok;
    for (int c = 0; c < NCFG; c++) begin
      g = 16 / NS_TAB[c];
      l = LT_TAB[c];
      prev_acc = -1;
      for (int t = 0; t < 6; t++) begin
        s = rand128();
        run_one(c, s, res, lat, ok, acc);
        n_cmp += 2;
        if (!ok || lat !== g + l + 1) begin
          n_bad++; $display("FAIL b2b_latency cfg%0d t%0d got %0d want %0d", c, t, lat, g + l + 1);
        end
        if (res !== ref_sub(s)) begin
          n_bad++; $display("FAIL b2b_data cfg%0d t%0d got %h want %h", c, t, res, ref_sub(s));
        end
        if (prev_acc >= 0) begin
          n_cmp++;
          if (acc - prev_acc !== g + l + 2) begin
            n_bad++; $display("FAIL b2b_period cfg%0d t%0d got %0d want %0d", c, t, acc - prev_acc, g + l + 2);
          end
        end
        prev_acc = acc;
      end
    end
  endtask

  initial begin
    build_table();
    rst = 1'b1;
    for (int c = 0; c < NCFG; c++) begin
      in_valid[c]  = 1'b0;
      out_ready[c] = 1'b1;
      state_in[c]  = '0;
    end
    test_reset();
    test_known_vectors();
    test_latency();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
